// File: rtl/timer_bus_ctrl.sv
// rtl/timer_bus_ctrl.sv - memory-mapped bus front end for the machine timer
//
// Purpose: accepts CPU load/store requests on a valid/ready bus, turns
// stores into timer write strobes, serves loads from the live timer outputs
// (atomic 64-bit mtime read via a shadow of the high word) and keeps a sticky
// machine timer interrupt.
//
// Ports:
//   clk, resetb                  clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we/req_addr/req_wdata    request (1 = store), byte address, store data
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_err          load data (0 for stores/errors), access error
//   t_wenl/t_wenh/t_sel/t_din    timer write strobes, mtime/mtimecmp select, data
//   t_mtimel/t_mtimeh/t_mtimecmp live timer values
//   t_cmp                        mtime == mtimecmp
//   mtip                         machine timer interrupt pending
module timer_bus_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        t_wenl,
  output logic        t_wenh,
  output logic        t_sel,
  output logic [31:0] t_din,
  input  logic [31:0] t_mtimel,
  input  logic [31:0] t_mtimeh,
  input  logic [63:0] t_mtimecmp,
  input  logic        t_cmp,
  output logic        mtip
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state;
  logic        we_q;
  logic        err_q;
  logic [1:0]  word_q;       // offset[3:2]: 0 mtime lo, 1 mtime hi, 2 cmp lo, 3 cmp hi
  logic        sel_q;
  logic [31:0] din_q;
  logic [31:0] rdata_q;
  logic        rerr_q;
  logic [31:0] shadow;
  logic        shadow_valid;
  logic        mtip_q;

  logic [31:0] offset;
  logic        req_err;
  logic        accept;
  logic        store_go;
  logic        cmp_clr;
  logic [31:0] rd_data;

  // Unsigned subtraction: an address below the base wraps to a huge offset
  // and therefore falls outside the window. The base is 16-byte aligned, so
  // offset[1:0] equals req_addr[1:0].
  assign offset  = req_addr - BASE_ADDR;
  assign req_err = (|offset[1:0]) || (|offset[31:4]);
  assign accept  = req_valid && req_ready;

  // Gating with resetb drops a store whose ACCESS cycle coincides with reset.
  assign store_go = resetb && (state == S_ACCESS) && we_q && !err_q;
  assign cmp_clr  = store_go && word_q[1];

  assign req_ready  = resetb && (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign t_wenl     = store_go && !word_q[0];
  assign t_wenh     = store_go && word_q[0];
  assign t_sel      = sel_q;
  assign t_din      = din_q;
  // The clear is visible in the ACCESS cycle itself, not only afterwards.
  assign mtip       = mtip_q && !cmp_clr;

  always_comb begin
    rd_data = 32'd0;
    case (word_q)
      2'd0:    rd_data = t_mtimel;
      2'd1:    rd_data = shadow_valid ? shadow : t_mtimeh;
      2'd2:    rd_data = t_mtimecmp[31:0];
      default: rd_data = t_mtimecmp[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      word_q       <= 2'd0;
      sel_q        <= 1'b0;
      din_q        <= 32'd0;
      rdata_q      <= 32'd0;
      rerr_q       <= 1'b0;
      shadow       <= 32'd0;
      shadow_valid <= 1'b0;
      mtip_q       <= 1'b0;
    end else begin
      // Clear has priority over a simultaneous compare hit.
      if (cmp_clr) begin
        mtip_q <= 1'b0;
      end else if (t_cmp) begin
        mtip_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q   <= req_we;
            err_q  <= req_err;
            word_q <= offset[3:2];
            // Timer-facing select/data only move for a store that will strobe.
            if (req_we && !req_err) begin
              sel_q <= offset[3];
              din_q <= req_wdata;
            end
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rerr_q <= err_q;
          if (we_q || err_q) begin
            rdata_q <= 32'd0;
          end else begin
            rdata_q <= rd_data;
          end
          if (!we_q && !err_q) begin
            if (word_q == 2'd0) begin
              shadow       <= t_mtimeh;
              shadow_valid <= 1'b1;
            end else if (word_q == 2'd1) begin
              shadow_valid <= 1'b0;
            end
          end
          if (store_go && !word_q[1]) begin
            shadow_valid <= 1'b0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/timer_bus_ctrl.md
Name: timer_bus_ctrl

Overview:
- Memory-mapped front end for the machine timer. Accepts CPU load/store requests on a valid/ready bus and turns stores into the timer's write strobes (wenl/wenh/sel/din).
- Serves loads from the timer's live outputs, with an atomic 64-bit mtime read through a shadow latch.
- Converts the timer's equality pulse into a sticky machine timer interrupt (mtip) for the core.
- Sits between the core's data bus and the timer block.

Parameters:
- BASE_ADDR, 32'h0000_4000, base of the 16-byte timer window; must be 16-byte aligned.

Ports:
- clk  in  1  clock
- resetb  in  1  reset; synchronous, active-low
- req_valid  in  1  bus request valid
- req_ready  out  1  request accepted when valid && ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid && ready
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  access error
- t_wenl  out  1  timer low-word write strobe
- t_wenh  out  1  timer high-word write strobe
- t_sel  out  1  0 = mtime, 1 = mtimecmp
- t_din  out  32  timer write data
- t_mtimel  in  32  live mtime[31:0]
- t_mtimeh  in  32  live mtime[63:32]
- t_mtimecmp  in  64  live mtimecmp
- t_cmp  in  1  mtime == mtimecmp
- mtip  out  1  machine timer interrupt pending

Behaviour:
- Address map, offset = req_addr - BASE_ADDR:
  - 0x0 mtime lo
  - 0x4 mtime hi
  - 0x8 mtimecmp lo
  - 0xC mtimecmp hi
- Error conditions: req_addr[1:0] != 0, or address outside [BASE_ADDR, BASE_ADDR+16). Result is resp_err=1, resp_rdata=0, no timer strobe.
- FSM states IDLE, ACCESS, RESP:
  - IDLE: req_ready=1. On req_valid, register we/offset/wdata/err and go to ACCESS.
  - ACCESS: req_ready=0. For a valid store, assert exactly one strobe for exactly one cycle. Offset 0x0/0x8 drives t_wenl; 0x4/0xC drives t_wenh. t_sel = offset[3]; t_din = registered wdata. For a load, capture read data into the response register. Go to RESP.
  - RESP: resp_valid=1; resp_rdata/resp_err held stable. Return to IDLE on resp_ready, otherwise stay. req_ready=0.
- Timing: minimum three cycles per transaction, so at most one outstanding. Back-to-back throughput is one request per 3 cycles.
- Strobes: t_wenl/t_wenh are 0 in every state except ACCESS for a valid store. t_din holds its last value otherwise.
- Atomic read:
  - A load of 0x0 returns t_mtimel, copies t_mtimeh into a 32-bit shadow in the same ACCESS cycle, and sets shadow_valid.
  - A load of 0x4 returns the shadow if shadow_valid, else t_mtimeh; it then clears shadow_valid.
  - A store to 0x0 or 0x4 clears shadow_valid.
  - Loads of 0x8/0xC return t_mtimecmp[31:0] / [63:32] directly.
- mtip:
  - Sets on any cycle with t_cmp=1.
  - Clears in the ACCESS cycle of any valid store to 0x8 or 0xC.
  - Clear wins over a simultaneous set.
  - Loads never affect mtip.
- Reset (synchronous, resetb=0, including mid-transaction):
  - FSM goes to IDLE.
  - req_ready=1 after reset deasserts; during reset req_ready=0.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - t_wenl=t_wenh=0, t_sel=0, t_din=0.
  - mtip=0, shadow_valid=0, shadow=0.
  - An in-flight store whose ACCESS cycle coincides with reset is dropped (no strobe).
- Width rules: all data paths are 32 bit. The offset compare uses a full 32-bit subtraction; a wrap below BASE_ADDR counts as out of window.

Test Plan:
- Store 0x0000_1000 to BASE+0x8 -> one cycle later t_wenl=1, t_sel=1, t_din=0x1000, for exactly 1 cycle; resp_valid with resp_err=0, resp_rdata=0.
- Atomic read: timer at lo=0xFFFF_FFFF, hi=0x0000_0002. Load BASE+0x0 returns 0xFFFF_FFFF. Timer then carries to hi=3. Load BASE+0x4 returns 0x0000_0002. A second load of BASE+0x4 returns 3.
- mtip: pulse t_cmp=1 for one cycle -> mtip=1 and stays 1 through loads. Store to BASE+0xC -> mtip=0 in the ACCESS cycle. If t_cmp=1 in that same cycle, mtip remains 0.
- Errors: load at BASE+0x2 and store at BASE+0x10 -> resp_err=1, resp_rdata=0, no t_wenl/t_wenh.
- Backpressure: hold resp_ready=0 for 5 cycles after a load of BASE+0xC (mtimecmp hi=0xABCD_0001) -> resp_valid and resp_rdata=0xABCD_0001 stable throughout; req_ready=0; a new req_valid is not accepted until 1 cycle after resp_ready.
- Reset mid-op: assert resetb=0 in the ACCESS cycle of a store to BASE+0x4 -> no t_wenh pulse; mtip=0, resp_valid=0. After release, req_ready=1 and the next transaction completes normally.
